// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the byte-wide RAM and mem_arbiter.
//   IF  : if_req, if_addr, if_flush -> if_done, if_rdata
//   MEM : mem_req, mem_we, mem_addr, mem_size, mem_signed, mem_wdata -> mem_done, mem_rdata
//   RAM : ram_addr, ram_wr, ram_dout -> ram_din
//   busy: arbiter not idle, feeds the stall controller
// slave is the arbiter side; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_addr, mem_size, mem_signed, mem_wdata,
    input  ram_din,
    output if_done, if_rdata, mem_done, mem_rdata,
    output ram_addr, ram_wr, ram_dout, busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_addr, mem_size, mem_signed, mem_wdata,
    output ram_din,
    input  if_done, if_rdata, mem_done, mem_rdata,
    input  ram_addr, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between instruction fetch and the
// MEM-stage load/store path. Each request becomes a run of byte accesses;
// read bytes are assembled little-endian and loads are sign/zero extended.
// Ports: clk, rst (async, active-low), bus (mem_arbiter_if.slave) carrying
// the IF, MEM and RAM signals plus busy. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n, nbytes_q, nbytes_n, cnt_inc, req_bytes;
  logic [1:0]        lane;
  logic              own_mem_q, own_mem_n, sgn_q, sgn_n;
  logic [ADDR_W-1:0] base_q, base_n, ram_addr_q, ram_addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, rbuf_q, rbuf_n, ext;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_n, mem_rdata_q, mem_rdata_n;
  logic [7:0]        ram_dout_q, ram_dout_n;
  logic              ram_wr_q, ram_wr_n, if_done_q, if_done_n;
  logic              mem_done_q, mem_done_n, busy_q;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // In read cycle C(k+1) the byte addressed in Ck is on ram_din; it belongs to lane k-1.
  assign lane    = 2'(cnt_q - CNT_W'(1));

  // Byte count of a MEM request; size 11 behaves as a word.
  always_comb begin
    case (bus.mem_size)
      2'b00:   req_bytes = CNT_W'(1);
      2'b01:   req_bytes = CNT_W'(2);
      default: req_bytes = CNT_W'(4);
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    nbytes_n    = nbytes_q;
    own_mem_n   = own_mem_q;
    sgn_n       = sgn_q;
    base_n      = base_q;
    wdata_n     = wdata_q;
    rbuf_n      = rbuf_q;
    ram_addr_n  = ram_addr_q;
    ram_dout_n  = ram_dout_q;
    if_rdata_n  = if_rdata_q;
    mem_rdata_n = mem_rdata_q;
    ram_wr_n    = 1'b0;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    ext         = '0;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          own_mem_n  = 1'b1;
          base_n     = bus.mem_addr;
          nbytes_n   = req_bytes;
          wdata_n    = bus.mem_wdata;
          sgn_n      = bus.mem_signed;
          cnt_n      = '0;
          rbuf_n     = '0;
          ram_addr_n = bus.mem_addr;
          if (bus.mem_we) begin
            state_n    = WRITE;
            ram_wr_n   = 1'b1;
            ram_dout_n = bus.mem_wdata[7:0];
          end else begin
            state_n = READ;
          end
        end else if (bus.if_req && !bus.if_flush) begin
          own_mem_n  = 1'b0;
          base_n     = bus.if_addr;
          nbytes_n   = CNT_W'(4);
          sgn_n      = 1'b0;
          cnt_n      = '0;
          rbuf_n     = '0;
          ram_addr_n = bus.if_addr;
          state_n    = READ;
        end
      end

      READ: begin
        if (!own_mem_q && bus.if_flush) begin
          state_n = IDLE;
        end else begin
          if (cnt_q != '0) rbuf_n[{lane, 3'b000} +: 8] = bus.ram_din;
          if (cnt_q == nbytes_q) begin
            // Tail cycle: last byte lands now, result goes out with the done pulse.
            state_n = DONE;
            case (nbytes_q)
              CNT_W'(1): ext = {{24{sgn_q & rbuf_n[7]}}, rbuf_n[7:0]};
              CNT_W'(2): ext = {{16{sgn_q & rbuf_n[15]}}, rbuf_n[15:0]};
              default:   ext = rbuf_n;
            endcase
            if (own_mem_q) begin
              mem_done_n  = 1'b1;
              mem_rdata_n = ext;
            end else begin
              if_done_n  = 1'b1;
              if_rdata_n = rbuf_n;
            end
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc != nbytes_q) ram_addr_n = base_q + ADDR_W'(cnt_inc);
          end
        end
      end

      WRITE: begin
        if (cnt_inc == nbytes_q) begin
          state_n    = DONE;
          mem_done_n = 1'b1;
        end else begin
          cnt_n      = cnt_inc;
          ram_wr_n   = 1'b1;
          ram_addr_n = base_q + ADDR_W'(cnt_inc);
          ram_dout_n = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      own_mem_q   <= 1'b0;
      sgn_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      nbytes_q    <= nbytes_n;
      own_mem_q   <= own_mem_n;
      sgn_q       <= sgn_n;
      base_q      <= base_n;
      wdata_q     <= wdata_n;
      rbuf_q      <= rbuf_n;
      ram_addr_q  <= ram_addr_n;
      ram_dout_q  <= ram_dout_n;
      ram_wr_q    <= ram_wr_n;
      if_done_q   <= if_done_n;
      if_rdata_q  <= if_rdata_n;
      mem_done_q  <= mem_done_n;
      mem_rdata_q <= mem_rdata_n;
      busy_q      <= (state_n != IDLE);
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port. Shares it between instruction fetch (IF) and the MEM-stage load/store path.
- Splits each request into a sequence of byte accesses, assembles read data little-endian, and applies sign or zero extension to loads.
- Sits between the IF/MEM stages and the RAM. Its `busy` and `done` outputs feed the stall controller that drives `stall_state`.

Parameters:
- ADDR_W, 32, width of all byte addresses (same as `MemBus`).

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF requests a 32-bit word read; held until if_done or if_flush
- if_addr  in  ADDR_W  IF byte address; stable while if_req is high
- if_flush  in  1  abort any IF transaction in progress (branch redirect)
- if_done  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  32  fetched word
- mem_req  in  1  MEM-stage request; all mem_* inputs held stable until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  base byte address
- mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- mem_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- mem_wdata  in  32  store data; low bytes are used first
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  32  extended load data; valid with mem_done
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid one cycle after its address is presented
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst low, asynchronous): state is IDLE. All outputs are 0, including ram_wr, if_done and mem_done. Internal counters and buffers are cleared. A transaction in progress is discarded, with no done pulse and no further RAM write.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - At a rising edge, a pending mem_req has priority over if_req.
  - Grant latches the owner, base address, N = bytes (1/2/4), write data, signed flag and we. It clears cnt.
  - Next state is WRITE if mem_we is 1, otherwise READ. An IF grant is always READ with N = 4.
  - No preemption after grant.
- READ, cycle Ck (k = 1..N):
  - ram_addr = base + (k-1), modulo 2^ADDR_W. ram_wr = 0.
  - The byte presented in Ck is captured at the end of Ck+1 into byte lane k-1.
  - C(N+1) is a capture-only tail cycle.
  - Then go to DONE.
- WRITE, cycle Ck (k = 1..N):
  - ram_addr = base + (k-1), ram_wr = 1, ram_dout = wdata byte k-1.
  - After CN go to DONE.
  - ram_wr is never high outside WRITE.
- DONE: one cycle.
  - Pulse the owner's done and present its rdata. Loads: bytes above N are filled with the sign bit of byte N-1 if mem_signed is 1, else 0. IF data is the raw word.
  - Requests are ignored in this cycle. Next state is IDLE.
  - Requesters must deassert or change their request at the edge that ends DONE.
- Latency from the grant edge to the done cycle: read C(N+2), write C(N+1). Word read: done in C6. Byte store: done in C2.
- if_flush:
  - While an IF transaction is in READ: go to IDLE at the next edge, with no if_done; captured data is discarded.
  - In IDLE: if_flush suppresses an IF grant that cycle. mem_req is still eligible.
  - Ignored during MEM transactions. MEM transactions are never aborted.
- Misaligned addresses are permitted. Addresses wrap modulo 2^ADDR_W.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
1. rst low for 3 cycles, random inputs -> all outputs 0; first grant occurs only after rst rises.
2. IF read at 0x100, RAM bytes 0x13 0x05 0x10 0x00 -> ram_addr 0x100..0x103 in C1..C4; if_done in C6 with if_rdata = 0x00100513; busy high C1..C6.
3. if_req@0x100 and mem_req (signed byte load at 0x200 = 0x80) at the same edge -> MEM served first, mem_rdata = 0xFFFFFF80 at C3; IF granted after, if_done 6 cycles later. Repeat with mem_signed = 0 -> 0x00000080.
4. Half store 0xABCD1234 to 0x300 -> C1: addr 0x300, wr = 1, dout 0x34; C2: addr 0x301, dout 0x12; mem_done at C3; ram_wr is 0 in every other cycle.
5. if_flush in C3 of an IF read -> IDLE next edge, no if_done, ram_wr stays 0; a following mem_req word load at 0xFFFFFFFE presents addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
6. rst low in C2 of a word store -> ram_wr drops immediately without waiting for a clock edge; after release, state is IDLE, there is no mem_done, and the RAM holds only the C1 byte.
